// File: rtl/tattr_dma.sv
// Register-programmed copy engine: fetches 32-bit words from system memory and
// writes them byte-by-byte into the tile-attribute RAM. Optional macro TATTR_DMA_VBLANK_WAIT_EN.
module tattr_dma #(
    parameter int  TATTR_SIZE = 512,
    parameter int  AW         = 32,
    localparam int TA_W       = $clog2(TATTR_SIZE)
) (
    input  logic            wclk,
    input  logic            rst_n,
    input  logic [1:0]      reg_addr,
    input  logic [31:0]     reg_wdata,
    input  logic            reg_wenable,
    output logic [31:0]     reg_rdata,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_req,
    input  logic            mem_ready,
    input  logic [31:0]     mem_rdata,
    output logic [TA_W-1:0] tattr_addr,
    output logic [7:0]      tattr_wdata,
    output logic            tattr_wenable,
    input  logic            vblank,
    output logic            irq
);

`ifdef TATTR_DMA_VBLANK_WAIT_EN
    typedef enum logic [1:0] {IDLE, FETCH, WRITE, WAIT_VB} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;
`endif

    state_t state, next_state;

    logic [AW-3:0]   src_reg;
    logic [TA_W-1:0] dst_reg;
    logic [9:0]      len_reg;
    logic            irq_en;
    logic            done;

    logic [AW-3:0]   cur_src;
    logic [TA_W-1:0] cur_dst;
    logic [9:0]      remaining;
    logic [31:0]     word;
    logic [1:0]      byte_sel;

    logic busy;
    logic ctrl_wr;
    logic start;
    logic fetch_done;
    logic last_write;
    logic set_done;

    assign busy       = (state != IDLE);
    assign ctrl_wr    = reg_wenable && (reg_addr == 2'd3);
    assign start      = ctrl_wr && reg_wdata[0] && !busy;
    assign fetch_done = (state == FETCH) && mem_ready;
    assign last_write = (state == WRITE) && (remaining == 10'd1);
    assign set_done   = (start && (len_reg == 10'd0)) || last_write;

`ifdef TATTR_DMA_VBLANK_WAIT_EN
    logic vb_meta, vb_sync;

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            vb_meta <= 1'b0;
            vb_sync <= 1'b0;
        end else begin
            vb_meta <= vblank;
            vb_sync <= vb_meta;
        end
    end
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
`endif

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && (len_reg != 10'd0)) begin
`ifdef TATTR_DMA_VBLANK_WAIT_EN
                    next_state = WAIT_VB;
`else
                    next_state = FETCH;
`endif
                end
            end
`ifdef TATTR_DMA_VBLANK_WAIT_EN
            WAIT_VB: if (vb_sync) next_state = FETCH;
`endif
            FETCH: if (mem_ready) next_state = WRITE;
            WRITE: begin
                if (remaining == 10'd1)     next_state = IDLE;
                else if (byte_sel == 2'd3)  next_state = FETCH;
            end
            default: next_state = IDLE;
        endcase
    end

    // Programming registers are frozen while a copy is in flight
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            src_reg <= '0;
            dst_reg <= '0;
            len_reg <= '0;
            irq_en  <= 1'b0;
        end else if (reg_wenable) begin
            case (reg_addr)
                2'd0: if (!busy) src_reg <= reg_wdata[AW-1:2];
                2'd1: if (!busy) dst_reg <= reg_wdata[TA_W-1:0];
                2'd2: begin
                    if (!busy) begin
                        if (reg_wdata > 32'(TATTR_SIZE)) len_reg <= 10'(TATTR_SIZE);
                        else                             len_reg <= reg_wdata[9:0];
                    end
                end
                default: irq_en <= reg_wdata[1];
            endcase
        end
    end

    // Setting done wins over a simultaneous clear so clear+start of an empty copy still completes
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n)                     done <= 1'b0;
        else if (set_done)              done <= 1'b1;
        else if (ctrl_wr && reg_wdata[2]) done <= 1'b0;
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
            word      <= '0;
            byte_sel  <= '0;
        end else if (start) begin
            cur_src   <= src_reg;
            cur_dst   <= dst_reg;
            remaining <= len_reg;
        end else if (fetch_done) begin
            word     <= mem_rdata;
            cur_src  <= cur_src + (AW-2)'(1);
            byte_sel <= 2'd0;
        end else if (state == WRITE) begin
            cur_dst   <= cur_dst + TA_W'(1);
            remaining <= remaining - 10'd1;
            byte_sel  <= byte_sel + 2'd1;
        end
    end

    always_comb begin
        tattr_wdata = word[7:0];
        case (byte_sel)
            2'd1:    tattr_wdata = word[15:8];
            2'd2:    tattr_wdata = word[23:16];
            2'd3:    tattr_wdata = word[31:24];
            default: tattr_wdata = word[7:0];
        endcase
    end

    always_comb begin
        reg_rdata = 32'd0;
        case (reg_addr)
            2'd0:    reg_rdata = 32'({src_reg, 2'b00});
            2'd1:    reg_rdata = 32'(dst_reg);
            2'd2:    reg_rdata = {22'd0, len_reg};
            default: reg_rdata = {29'd0, done, irq_en, busy};
        endcase
    end

    assign mem_req       = (state == FETCH);
    assign mem_addr      = {cur_src, 2'b00};
    assign tattr_wenable = (state == WRITE);
    assign tattr_addr    = cur_dst;
    assign irq           = done && irq_en;

endmodule

// File: tb/tb_tattr_dma.sv
// Directed self-checking bench for tattr_dma with a wait-state memory model
// and a tile-attribute write monitor.
module tb_tattr_dma;

    logic        wclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  reg_addr = 2'd0;
    logic [31:0] reg_wdata = 32'd0;
    logic        reg_wenable = 1'b0;
    logic [31:0] reg_rdata;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [8:0]  tattr_addr;
    logic [7:0]  tattr_wdata;
    logic        tattr_wenable;
    logic        vblank = 1'b0;
    logic        irq;

    tattr_dma dut (
        .wclk(wclk), .rst_n(rst_n),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wenable(reg_wenable), .reg_rdata(reg_rdata),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .tattr_addr(tattr_addr), .tattr_wdata(tattr_wdata), .tattr_wenable(tattr_wenable),
        .vblank(vblank), .irq(irq)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          wait_cycles = 0;
    int          wcnt = 0;
    int          fetches = 0;
    int          req_cycles = 0;
    logic [31:0] exp_addr = 32'd0;
    logic [31:0] mem_model [int unsigned];
    wr_t         wq [$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge wclk) cyc++;

    // Memory model: answers each request after wait_cycles idle cycles
    always @(negedge wclk) begin
        if (!rst_n) begin
            mem_ready = 1'b0;
            wcnt = 0;
        end else if (mem_req) begin
            req_cycles++;
            checkOutput("mem_addr", mem_addr, exp_addr);
            if (wcnt == wait_cycles) begin
                mem_ready = 1'b1;
                mem_rdata = memRead(mem_addr);
                wcnt = 0;
                exp_addr = exp_addr + 32'd4;
                fetches++;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ready = 1'b0;
        end
    end

    always @(negedge wclk) begin
        if (tattr_wenable) wq.push_back('{int'(tattr_addr), int'(tattr_wdata), cyc});
    end

    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        @(negedge wclk);
        reg_addr    = a;
        reg_wdata   = d;
        reg_wenable = 1'b1;
        @(negedge wclk);
        reg_wenable = 1'b0;
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] d);
        reg_addr = a;
        #1;
        d = reg_rdata;
    endtask

    task automatic waitIdle(input int budget, output int seen_cyc);
        logic [31:0] r;
        seen_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge wclk);
            readReg(2'd3, r);
            if (r[0] == 1'b0) begin
                seen_cyc = cyc;
                break;
            end
        end
        if (seen_cyc < 0) checkOutput("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic checkWrites(input string tag, input int addrs[], input int datas[]);
        checkOutput({tag, "_count"}, 32'(wq.size()), 32'(addrs.size()));
        for (int i = 0; i < addrs.size() && i < wq.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), 32'(wq[i].a), 32'(addrs[i]));
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(wq[i].d), 32'(datas[i]));
        end
    endtask

    initial begin
        logic [31:0] r;
        int          seen;
        int          req_before;

        mem_model[32'h100] = 32'h4433_2211;
        mem_model[32'h104] = 32'h8877_6655;
        mem_model[32'h200] = 32'hDDCC_BBAA;
        mem_model[32'h204] = 32'h5566_7788;
        mem_model[32'h300] = 32'hA1B2_C3D4;

        // Reset values
        repeat (2) @(negedge wclk);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_tattr_we", 32'(tattr_wenable), 32'd0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_tattr_addr", 32'(tattr_addr), 32'd0);
        checkOutput("rst_tattr_wdata", 32'(tattr_wdata), 32'd0);
        rst_n = 1'b1;
        @(negedge wclk);
        for (int i = 0; i < 4; i++) begin
            readReg(2'(i), r);
            checkOutput($sformatf("rst_reg%0d", i), r, 32'd0);
        end

        // Test 1: two full words, zero wait states
        $display("[TB] eight-byte copy, zero wait");
        wait_cycles = 0;
        applyStimulus(2'd0, 32'h0000_0100);
        applyStimulus(2'd1, 32'd0);
        applyStimulus(2'd2, 32'd8);
        readReg(2'd0, r);
        checkOutput("src_readback", r, 32'h100);
        exp_addr = 32'h100;
        wq.delete();
        applyStimulus(2'd3, 32'h1);
        #1;
        checkOutput("t1_req_next_cycle", 32'(mem_req), 32'd1);
        waitIdle(100, seen);
        checkWrites("t1", '{0, 1, 2, 3, 4, 5, 6, 7},
                    '{'h11, 'h22, 'h33, 'h44, 'h55, 'h66, 'h77, 'h88});
        if (wq.size() == 8) begin
            checkOutput("t1_span", 32'(wq[7].c - wq[0].c), 32'd8);
            checkOutput("t1_done_latency", 32'(seen), 32'(wq[7].c + 1));
        end
        readReg(2'd3, r);
        checkOutput("t1_ctrl", r, 32'b100);
        checkOutput("t1_irq_masked", 32'(irq), 32'd0);

        // Test 2: wrap around the top of the RAM with slow memory and a partial word
        $display("[TB] five-byte copy with wrap and wait states");
        applyStimulus(2'd3, 32'b100);
        wait_cycles = 3;
        fetches = 0;
        applyStimulus(2'd0, 32'h0000_0200);
        applyStimulus(2'd1, 32'd510);
        applyStimulus(2'd2, 32'd5);
        exp_addr = 32'h200;
        wq.delete();
        applyStimulus(2'd3, 32'h1);
        waitIdle(100, seen);
        checkWrites("t2", '{510, 511, 0, 1, 2}, '{'hAA, 'hBB, 'hCC, 'hDD, 'h88});
        checkOutput("t2_fetches", 32'(fetches), 32'd2);
        readReg(2'd3, r);
        checkOutput("t2_ctrl", r, 32'b100);

        // Test 3: zero-length starts, with and without the interrupt enabled
        $display("[TB] zero-length starts and irq");
        applyStimulus(2'd3, 32'b110);
        readReg(2'd3, r);
        checkOutput("t3_cleared", r, 32'b010);
        checkOutput("t3_irq_cleared", 32'(irq), 32'd0);
        applyStimulus(2'd2, 32'd0);
        req_before = req_cycles;
        applyStimulus(2'd3, 32'b011);
        readReg(2'd3, r);
        checkOutput("t3_done_en", r, 32'b110);
        checkOutput("t3_irq_on", 32'(irq), 32'd1);
        applyStimulus(2'd3, 32'b110);
        readReg(2'd3, r);
        checkOutput("t3_w1c", r, 32'b010);
        checkOutput("t3_irq_off", 32'(irq), 32'd0);
        applyStimulus(2'd3, 32'b001);
        readReg(2'd3, r);
        checkOutput("t3_done_dis", r, 32'b100);
        checkOutput("t3_irq_dis", 32'(irq), 32'd0);
        checkOutput("t3_no_mem_req", 32'(req_cycles), 32'(req_before));
        applyStimulus(2'd3, 32'b100);

        // Test 4: register writes while busy are ignored
        $display("[TB] busy lock");
        wait_cycles = 2;
        applyStimulus(2'd0, 32'h0000_0300);
        applyStimulus(2'd1, 32'h20);
        applyStimulus(2'd2, 32'd4);
        exp_addr = 32'h300;
        wq.delete();
        applyStimulus(2'd3, 32'h1);
        applyStimulus(2'd0, 32'h0000_FFFF);
        applyStimulus(2'd2, 32'd3);
        applyStimulus(2'd3, 32'h1);
        waitIdle(100, seen);
        repeat (10) @(negedge wclk);
        checkWrites("t4", '{'h20, 'h21, 'h22, 'h23}, '{'hD4, 'hC3, 'hB2, 'hA1});
        readReg(2'd0, r);
        checkOutput("t4_src_kept", r, 32'h300);
        readReg(2'd2, r);
        checkOutput("t4_len_kept", r, 32'd4);
        readReg(2'd3, r);
        checkOutput("t4_ctrl", r, 32'b100);
        applyStimulus(2'd2, 32'd600);
        readReg(2'd2, r);
        checkOutput("t4_len_sat600", r, 32'd512);
        applyStimulus(2'd2, 32'd513);
        readReg(2'd2, r);
        checkOutput("t4_len_sat513", r, 32'd512);
        applyStimulus(2'd2, 32'd512);
        readReg(2'd2, r);
        checkOutput("t4_len_512", r, 32'd512);
        applyStimulus(2'd3, 32'b100);

        // Test 5: reset during the second word
        $display("[TB] reset mid-transfer");
        wait_cycles = 0;
        applyStimulus(2'd0, 32'h0000_0100);
        applyStimulus(2'd1, 32'h40);
        applyStimulus(2'd2, 32'd8);
        exp_addr = 32'h100;
        wq.delete();
        applyStimulus(2'd3, 32'b011);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge wclk);
            #1;
            if (wq.size() == 5) begin
                seen = 1;
                break;
            end
        end
        checkOutput("t5_reached_word2", 32'(seen), 32'd1);
        checkOutput("t5_we_before", 32'(tattr_wenable), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_we_async", 32'(tattr_wenable), 32'd0);
        checkOutput("t5_req_async", 32'(mem_req), 32'd0);
        repeat (2) @(negedge wclk);
        rst_n = 1'b1;
        repeat (3) @(negedge wclk);
        checkOutput("t5_no_more_writes", 32'(wq.size()), 32'd5);
        checkOutput("t5_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 4; i++) begin
            readReg(2'(i), r);
            checkOutput($sformatf("t5_reg%0d", i), r, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got=running exp=finished");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
